// File: rtl/fpnew_pkg.sv
// Shared types for the FP opgroup slices: status flags, the sequencer retirement
// mode and small lane-index helpers.
package fpnew_pkg;

   typedef struct packed {
      logic nv;  // invalid operation
      logic dz;  // divide by zero
      logic of;  // overflow
      logic uf;  // underflow
      logic nx;  // inexact
   } status_t;

   typedef enum logic {
      SEQ_INORDER,
      SEQ_RR
   } seq_mode_e;

   function automatic seq_mode_e seq_mode(input bit in_order);
      return in_order ? SEQ_INORDER : SEQ_RR;
   endfunction

   // Lane index base+off taken modulo the number of lanes.
   function automatic int unsigned lane_wrap(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned num_lanes);
      return (base + off) % num_lanes;
   endfunction

endpackage

// File: rtl/fpnew_lane_order_fifo.sv
// Issue-order FIFO of lane indices: the head names the only lane allowed to retire.
module fpnew_lane_order_fifo
   import fpnew_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter int unsigned LaneW = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [LaneW-1:0] lane_i,
   input  logic             pop_i,
   output logic [LaneW-1:0] head_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PtrW  = $clog2(Depth);
   localparam int unsigned FillW = PtrW + 1;

   logic [LaneW-1:0] mem_reg [Depth];
   logic [PtrW-1:0]  wr_ptr_reg;
   logic [PtrW-1:0]  rd_ptr_reg;
   logic [FillW-1:0] fill_reg;
   logic [FillW-1:0] fill_next;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (fill_reg == '0);
   assign full_o  = (fill_reg == FillW'(Depth));
   assign head_o  = mem_reg[rd_ptr_reg];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      fill_next = fill_reg;
      case ({do_push, do_pop})
         2'b10:   fill_next = fill_reg + 1'b1;
         2'b01:   fill_next = fill_reg - 1'b1;
         default: fill_next = fill_reg;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= lane_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         fill_reg   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         fill_reg <= fill_next;
      end
   end

endmodule

// File: rtl/fpnew_opgroup_result_sequencer.sv
// Merges the result streams of the format slices of one opgroup into a single
// output stream, retiring either in issue order or round-robin by completion.
module fpnew_opgroup_result_sequencer
   import fpnew_pkg::*;
#(
   parameter int unsigned NumLanes  = 5,
   parameter int unsigned Width     = 32,
   parameter int unsigned Depth     = 4,
   parameter bit          InOrder   = 1'b1,
   parameter bit          OutputReg = 1'b0,
   parameter type         TagType   = logic,
   localparam int unsigned LaneW    = $clog2(NumLanes),
   localparam int unsigned CntW     = $clog2(Depth) + 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           flush_i,
   input  logic                           issue_valid_i,
   input  logic [LaneW-1:0]               issue_lane_i,
   output logic                           issue_ready_o,
   input  logic [NumLanes-1:0]            lane_valid_i,
   output logic [NumLanes-1:0]            lane_ready_o,
   input  logic [NumLanes-1:0][Width-1:0] lane_result_i,
   input  status_t [NumLanes-1:0]         lane_status_i,
   input  logic [NumLanes-1:0]            lane_ext_i,
   input  TagType [NumLanes-1:0]          lane_tag_i,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [Width-1:0]               result_o,
   output status_t                        status_o,
   output logic                           extension_bit_o,
   output TagType                         tag_o,
   output logic [CntW-1:0]                outstanding_o,
   output logic                           busy_o
);

   localparam seq_mode_e Mode = seq_mode(InOrder);

   logic [CntW-1:0]  count_reg;
   logic [CntW-1:0]  count_next;
   logic [LaneW-1:0] rr_ptr_reg;
   logic [LaneW-1:0] rr_ptr_next;
   logic [LaneW-1:0] rr_cand;
   logic             grant_valid;
   logic [LaneW-1:0] grant_idx;
   logic             stage_ready;
   logic             retire;
   logic             issue_fire;
   logic             can_track;
   logic             out_valid_reg;
   logic [LaneW-1:0] head_lane;
   logic             fifo_empty;
   logic             fifo_full;
   logic [Width-1:0] sel_result;
   status_t          sel_status;
   logic             sel_ext;
   TagType           sel_tag;

   generate
      if (Mode == SEQ_INORDER) begin : g_order
         fpnew_lane_order_fifo #(
            .Depth (Depth),
            .LaneW (LaneW)
         ) i_order_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (issue_fire),
            .lane_i  (issue_lane_i),
            .pop_i   (retire),
            .head_o  (head_lane),
            .empty_o (fifo_empty),
            .full_o  (fifo_full)
         );
         // The FIFO fill level tracks the outstanding count exactly.
         assign can_track = ~fifo_full;
      end else begin : g_no_order
         assign head_lane  = '0;
         assign fifo_empty = 1'b1;
         assign fifo_full  = 1'b0;
         assign can_track  = (count_reg < CntW'(Depth));
      end
   endgenerate

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      rr_cand     = '0;
      if (Mode == SEQ_INORDER) begin
         if (!fifo_empty && lane_valid_i[head_lane]) begin
            grant_valid = 1'b1;
            grant_idx   = head_lane;
         end
      end else begin
         for (int unsigned i = 0; i < NumLanes; i++) begin
            rr_cand = LaneW'(lane_wrap(32'(rr_ptr_reg), i, NumLanes));
            if (!grant_valid && lane_valid_i[rr_cand]) begin
               grant_valid = 1'b1;
               grant_idx   = rr_cand;
            end
         end
      end
   end

   // With the output register, a full register still accepts when it drains this cycle.
   assign stage_ready   = OutputReg ? (~out_valid_reg | out_ready_i) : out_ready_i;
   assign retire        = grant_valid & stage_ready & ~flush_i;
   assign issue_ready_o = ~flush_i & (can_track | retire);
   assign issue_fire    = issue_valid_i & issue_ready_o;

   generate
      for (genvar gi = 0; gi < NumLanes; gi++) begin : g_lane_ready
         assign lane_ready_o[gi] = flush_i | (retire & (grant_idx == LaneW'(gi)));
      end
   endgenerate

   always_comb begin
      count_next = count_reg;
      if (flush_i) begin
         count_next = '0;
      end else if (issue_fire && !retire) begin
         count_next = count_reg + 1'b1;
      end else if (!issue_fire && retire && (count_reg != '0)) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (flush_i) begin
         rr_ptr_next = '0;
      end else if (retire && (Mode == SEQ_RR)) begin
         rr_ptr_next = LaneW'(lane_wrap(32'(grant_idx), 1, NumLanes));
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_reg  <= '0;
         rr_ptr_reg <= '0;
      end else begin
         count_reg  <= count_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   always_comb begin
      sel_result = lane_result_i[grant_idx];
      sel_status = lane_status_i[grant_idx];
      sel_ext    = lane_ext_i[grant_idx];
      sel_tag    = lane_tag_i[grant_idx];
   end

   generate
      if (OutputReg) begin : g_out_reg
         logic [Width-1:0] result_reg;
         status_t          status_reg;
         logic             ext_reg;
         TagType           tag_reg;

         always_ff @(posedge clk_i) begin
            if (!rst_ni || flush_i) begin
               out_valid_reg <= 1'b0;
            end else if (stage_ready) begin
               out_valid_reg <= retire;
            end
         end

         always_ff @(posedge clk_i) begin
            if (retire) begin
               result_reg <= sel_result;
               status_reg <= sel_status;
               ext_reg    <= sel_ext;
               tag_reg    <= sel_tag;
            end
         end

         assign out_valid_o     = out_valid_reg & ~flush_i;
         assign result_o        = result_reg;
         assign status_o        = status_reg;
         assign extension_bit_o = ext_reg;
         assign tag_o           = tag_reg;
      end else begin : g_out_comb
         assign out_valid_reg   = 1'b0;
         assign out_valid_o     = grant_valid & ~flush_i;
         assign result_o        = sel_result;
         assign status_o        = sel_status;
         assign extension_bit_o = sel_ext;
         assign tag_o           = sel_tag;
      end
   endgenerate

   assign outstanding_o = count_reg;
   assign busy_o        = (count_reg != '0) | (|lane_valid_i) | out_valid_reg;

endmodule
